mem_stage: RTL

MEM_STAGE -- requirements
Module: MEM_Stage

---
 rtl/mem_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage. It holds the EXE/MEM and MEM/WB registers and
//            runs a request/ack handshake to a word-addressed SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic        WB_EN_in,
  input  logic [1:0]  MEM_CMD_in,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] src2_val_in,
  input  logic [4:0]  Dst_in,
  output logic        sram_req,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ack,
  output logic        freeze,
  output logic [4:0]  Dst_MEM,
  output logic        WB_EN_MEM_out,
  output logic [31:0] Result_Alu_Mem,
  output logic [31:0] PC_WB,
  output logic        WB_EN_WB,
  output logic        MEM_R_EN_WB,
  output logic [31:0] ALU_res_WB,
  output logic [31:0] Mem_data_WB,
  output logic [4:0]  Dst_WB
);

  localparam logic [1:0] C_CMD_LOAD  = 2'b01;
  localparam logic [1:0] C_CMD_STORE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;

  logic [31:0] r_pc_m;
  logic        r_wb_en_m;
  logic [1:0]  r_cmd_m;
  logic [31:0] r_alu_m;
  logic [31:0] r_src2_m;
  logic [4:0]  r_dst_m;

  logic        r_req;
  logic        r_we;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [31:0] r_pc_wb;
  logic        r_wb_en_wb;
  logic        r_mem_r_en_wb;
  logic [31:0] r_alu_wb;
  logic [31:0] r_mem_data_wb;
  logic [4:0]  r_dst_wb;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;

  assign w_is_load  = (r_cmd_m == C_CMD_LOAD);
  assign w_is_store = (r_cmd_m == C_CMD_STORE);
  assign w_is_mem   = w_is_load || w_is_store;

  // Releasing the stall in DONE lets the next op enter on the same edge the
  // finished op retires, so a memory op costs exactly ack-wait + 2 cycles.
  assign freeze = w_is_mem && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_m    <= 32'd0;
      r_wb_en_m <= 1'b0;
      r_cmd_m   <= 2'b00;
      r_alu_m   <= 32'd0;
      r_src2_m  <= 32'd0;
      r_dst_m   <= 5'd0;
    end else if (!freeze) begin
      r_pc_m    <= PC_in;
      r_wb_en_m <= WB_EN_in;
      r_cmd_m   <= MEM_CMD_in;
      r_alu_m   <= ALU_res_in;
      r_src2_m  <= src2_val_in;
      r_dst_m   <= Dst_in;
    end
  end

  // Request fields are only non-zero while the FSM sits in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            r_state <= S_ACCESS;
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= r_alu_m[17:2];
            r_wdata <= r_src2_m;
          end
        end
        S_ACCESS: begin
          if (sram_ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 32'd0;
            if (w_is_load) begin
              r_rdata <= sram_rdata;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= 16'd0;
          r_wdata <= 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || freeze) begin
      r_pc_wb       <= 32'd0;
      r_wb_en_wb    <= 1'b0;
      r_mem_r_en_wb <= 1'b0;
      r_alu_wb      <= 32'd0;
      r_mem_data_wb <= 32'd0;
      r_dst_wb      <= 5'd0;
    end else begin
      r_pc_wb       <= r_pc_m;
      r_wb_en_wb    <= r_wb_en_m;
      r_mem_r_en_wb <= w_is_load;
      r_alu_wb      <= r_alu_m;
      r_mem_data_wb <= w_is_load ? r_rdata : 32'd0;
      r_dst_wb      <= r_dst_m;
    end
  end

  assign sram_req       = r_req;
  assign sram_we        = r_we;
  assign sram_addr      = r_addr;
  assign sram_wdata     = r_wdata;

  assign Dst_MEM        = r_dst_m;
  assign WB_EN_MEM_out  = r_wb_en_m;
  assign Result_Alu_Mem = r_alu_m;

  assign PC_WB          = r_pc_wb;
  assign WB_EN_WB       = r_wb_en_wb;
  assign MEM_R_EN_WB    = r_mem_r_en_wb;
  assign ALU_res_WB     = r_alu_wb;
  assign Mem_data_WB    = r_mem_data_wb;
  assign Dst_WB         = r_dst_wb;

endmodule
`default_nettype wire
